// File: rtl/window_addr_sequencer.sv
// rtl/window_addr_sequencer.sv - raster 3x3 window address generator over a zero-padded image
// Optional abort input enabled by defining WAS_ABORT_EN.
module window_addr_sequencer #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 600,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef WAS_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] a0,
    output logic [AW-1:0] a1,
    output logic [AW-1:0] a2,
    output logic [AW-1:0] a3,
    output logic [AW-1:0] a4,
    output logic [AW-1:0] a5,
    output logic [AW-1:0] a6,
    output logic [AW-1:0] a7,
    output logic [AW-1:0] a8,
    output logic [AW-1:0] opix
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] a_q [9];
    logic          last_col;
    logic          last_row;
    logic [AW-1:0] step;

    // Offset of window tap i from the window base in the padded layout.
    function automatic logic [AW-1:0] win_off(input int i);
        return AW'((i / 3) * (IMG_W + 2) + (i % 3));
    endfunction

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // End of row jumps over the right pad of this row and left pad of the next.
    assign step     = last_col ? AW'(3) : AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            col       <= '0;
            row       <= '0;
            opix      <= '0;
            for (int i = 0; i < 9; i++) a_q[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        col       <= '0;
                        row       <= '0;
                        opix      <= '0;
                        for (int i = 0; i < 9; i++) a_q[i] <= win_off(i);
                    end
                end
                RUN: begin
`ifdef WAS_ABORT_EN
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        opix      <= '0;
                        for (int i = 0; i < 9; i++) a_q[i] <= '0;
                    end else
`endif
                    if (out_ready) begin
                        if (last_col && last_row) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            opix <= opix + AW'(1);
                            for (int i = 0; i < 9; i++) a_q[i] <= a_q[i] + step;
                            if (last_col) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];
    assign a4 = a_q[4];
    assign a5 = a_q[5];
    assign a6 = a_q[6];
    assign a7 = a_q[7];
    assign a8 = a_q[8];
endmodule
